load_store_unit: RTL and testbench

// - Memory stage of the RV32I core, directly downstream of the ALU.
// - Takes the ALU result as the effective address and runs one data-memory transaction

---
 rtl/rv32i_pkg.sv | 23 ++
 rtl/lsu_align.sv | 64 ++++++
 rtl/load_store_unit.sv | 170 +++++++++++++++++
 tb/tb_load_store_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the memory stage: funct3 width codes, LSU state
// encoding and the datapath width.
package rv32i_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        FAULT  = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store strobes and replicated write data, load
// extraction with sign/zero extension, and legality/alignment decode of funct3.
module lsu_align
    import rv32i_pkg::*;
(
    input  logic [2:0]      funct3_i,
    input  logic            is_store_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [3:0]      wstrb_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            misaligned_o,
    output logic            illegal_o
);

    logic [XLEN-1:0] rdata_shifted;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;

    always_comb begin
        rdata_shifted = rdata_i >> {addr_lo_i, 3'b000};
        byte_sel      = rdata_shifted[7:0];
        half_sel      = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        wstrb_o      = 4'b0000;
        wdata_o      = wdata_i;
        rdata_o      = rdata_i;
        misaligned_o = 1'b0;
        illegal_o    = 1'b0;
        // Load and store codes overlap for B/H/W; the unsigned codes are load-only.
        case (funct3_i)
            F3_LB: begin
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{byte_sel[7]}}, byte_sel};
                if (is_store_i) wstrb_o = 4'b0001 << addr_lo_i;
            end
            F3_LH: begin
                misaligned_o = addr_lo_i[0];
                wdata_o      = {2{wdata_i[15:0]}};
                rdata_o      = {{16{half_sel[15]}}, half_sel};
                if (is_store_i) wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            end
            F3_LW: begin
                misaligned_o = |addr_lo_i;
                if (is_store_i) wstrb_o = 4'b1111;
            end
            F3_LBU: begin
                illegal_o = is_store_i;
                rdata_o   = {24'h000000, byte_sel};
            end
            F3_LHU: begin
                illegal_o    = is_store_i;
                misaligned_o = addr_lo_i[0];
                rdata_o      = {16'h0000, half_sel};
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory stage: accepts one access from execute, runs it over a req/ready
// memory handshake with timeout, and returns extended load data to writeback.
module load_store_unit
    import rv32i_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_is_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [4:0]      req_rd,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            done,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            err,
    output lsu_state_e      dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // the source must hold it until then. mem_req and its fields stay stable until
    // mem_ready is seen on a rising edge, or until the timeout aborts the access.

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]      f3_q;
    logic [1:0]      addr_lo_q;
    logic [4:0]      rd_q;
    logic            req_ready_q, mem_req_q, mem_we_q;
    logic [XLEN-1:0] mem_addr_q, mem_wdata_q, wb_data_q;
    logic [3:0]      mem_wstrb_q;
    logic            done_q, wb_valid_q, err_q;
    logic [4:0]      wb_rd_q;

    logic            in_idle;
    logic [2:0]      al_f3;
    logic            al_store;
    logic [1:0]      al_addr_lo;
    logic [3:0]      al_wstrb;
    logic [XLEN-1:0] al_wdata, al_rdata;
    logic            al_misaligned, al_illegal;

    // One aligner: decodes the incoming request in IDLE, the held access otherwise.
    always_comb begin
        in_idle    = (state_q == IDLE);
        al_f3      = in_idle ? req_funct3    : f3_q;
        al_store   = in_idle ? req_is_store  : mem_we_q;
        al_addr_lo = in_idle ? req_addr[1:0] : addr_lo_q;
    end

    lsu_align u_align (
        .funct3_i     (al_f3),
        .is_store_i   (al_store),
        .addr_lo_i    (al_addr_lo),
        .wdata_i      (req_wdata),
        .rdata_i      (mem_rdata),
        .wstrb_o      (al_wstrb),
        .wdata_o      (al_wdata),
        .rdata_o      (al_rdata),
        .misaligned_o (al_misaligned),
        .illegal_o    (al_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            f3_q        <= 3'b000;
            addr_lo_q   <= 2'b00;
            rd_q        <= 5'd0;
            req_ready_q <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= 4'b0000;
            done_q      <= 1'b0;
            wb_valid_q  <= 1'b0;
            err_q       <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= '0;
        end else begin
            done_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        req_ready_q <= 1'b0;
                        cnt_q       <= '0;
                        if (al_illegal || al_misaligned) begin
                            state_q <= FAULT;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state_q     <= ACCESS;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= req_is_store;
                            mem_addr_q  <= {req_addr[31:2], 2'b00};
                            mem_wdata_q <= al_wdata;
                            mem_wstrb_q <= al_wstrb;
                            f3_q        <= req_funct3;
                            addr_lo_q   <= req_addr[1:0];
                            rd_q        <= req_rd;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        state_q   <= DONE;
                        mem_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        if (!mem_we_q) begin
                            wb_valid_q <= 1'b1;
                            wb_rd_q    <= rd_q;
                            wb_data_q  <= al_rdata;
                        end
                    end else if (cnt_q == CNT_MAX) begin
                        state_q   <= FAULT;
                        mem_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        err_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE, FAULT: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    mem_req_q   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        req_ready = req_ready_q;
        mem_req   = mem_req_q;
        mem_we    = mem_we_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        mem_wstrb = mem_wstrb_q;
        done      = done_q;
        wb_valid  = wb_valid_q;
        wb_rd     = wb_rd_q;
        wb_data   = wb_data_q;
        err       = err_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: driver issues accesses and answers the
// memory side, a monitor scores done/writeback and memory transfers from queues.
module tb_load_store_unit;
    import rv32i_pkg::*;

    localparam int TMO = 8;
    localparam int K_OK = 0;
    localparam int K_FAULT = 1;
    localparam int K_TMO = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        done, wb_valid, err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    lsu_state_e  dbg_state;

    int n_checks = 0;
    int n_fail = 0;

    logic [38:0] exp_q[$];
    logic [68:0] mem_exp_q[$];
    logic [38:0] mon_e;
    logic [68:0] mon_m;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .done(done), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .err(err),
        .dbg_state(dbg_state)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every done pulse and every memory completion is popped and scored.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                chk("done_unexpected", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("err", err, mon_e[38]);
                chk("wb_valid", wb_valid, mon_e[37]);
                if (mon_e[37]) begin
                    chk("wb_rd", wb_rd, mon_e[36:32]);
                    chk("wb_data", wb_data, mon_e[31:0]);
                end
            end
        end
        if (rst_n && mem_req && mem_ready) begin
            if (mem_exp_q.size() == 0) begin
                chk("mem_unexpected", 1, 0);
            end else begin
                mon_m = mem_exp_q.pop_front();
                chk("mem_we", mem_we, mon_m[68]);
                chk("mem_addr", mem_addr, mon_m[67:36]);
                chk("mem_wstrb", mem_wstrb, mon_m[35:32]);
                if (mon_m[68]) chk("mem_wdata", mem_wdata, mon_m[31:0]);
            end
        end
    end

    task automatic issue(input string name, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                         input logic [31:0] rdata, input int k, input int kind,
                         input logic [31:0] exp_data, input logic [3:0] exp_wstrb,
                         input logic [31:0] exp_mwdata);
        int lat, nreq, w, exp_lat, exp_nreq;
        logic rr0;
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({name, " ready_before_issue"}, req_ready, 1);
        if (kind == K_OK) mem_exp_q.push_back({st, addr & 32'hFFFF_FFFC, exp_wstrb, exp_mwdata});
        exp_q.push_back({kind != K_OK, (kind == K_OK) && !st, rd, exp_data});
        req_valid = 1'b1;
        req_is_store = st;
        req_funct3 = f3;
        req_addr = addr;
        req_wdata = wdata;
        req_rd = rd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rr0 = req_ready;
        lat = -1;
        nreq = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            if (mem_req) nreq++;
            mem_ready = (k == i);
            mem_rdata = rdata;
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0;
        exp_lat = (kind == K_FAULT) ? 0 : (kind == K_TMO) ? TMO : k + 1;
        exp_nreq = (kind == K_FAULT) ? 0 : (kind == K_TMO) ? TMO : k + 1;
        chk({name, " busy_ready_low"}, rr0, 0);
        chk({name, " done_latency"}, lat, exp_lat);
        chk({name, " mem_req_cycles"}, nreq, exp_nreq);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcount;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_is_store = 1'b0;
        req_funct3 = 3'b000;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        req_rd = 5'd0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst req_ready", req_ready, 1);
        chk("rst mem_req", mem_req, 0);
        chk("rst mem_we", mem_we, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_wstrb", mem_wstrb, 0);
        chk("rst done", done, 0);
        chk("rst wb_valid", wb_valid, 0);
        chk("rst wb_data", wb_data, 0);
        chk("rst err", err, 0);
        chk("rst state", dbg_state, IDLE);
        @(negedge clk);
        rst_n = 1'b1;

        // Stray mem_ready while idle must not start or finish anything.
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        chk("idle mem_ready ignored", dbg_state, IDLE);

        //     name       st    f3      addr          wdata          rd     rdata          k   kind     exp_data       wstrb    mwdata
        issue("LW 0x100", 1'b0, 3'b010, 32'h0000_0100, 32'h0,         5'd5,  32'hDEAD_BEEF, 0,  K_OK,    32'hDEAD_BEEF, 4'b0000, 32'h0);
        issue("LB 0x103", 1'b0, 3'b000, 32'h0000_0103, 32'h0,         5'd6,  32'h8000_0000, 0,  K_OK,    32'hFFFF_FF80, 4'b0000, 32'h0);
        issue("LBU 0x103",1'b0, 3'b100, 32'h0000_0103, 32'h0,         5'd7,  32'h8000_0000, 0,  K_OK,    32'h0000_0080, 4'b0000, 32'h0);
        issue("LH 0x102", 1'b0, 3'b001, 32'h0000_0102, 32'h0,         5'd8,  32'h8001_0000, 1,  K_OK,    32'hFFFF_8001, 4'b0000, 32'h0);
        issue("LHU 0x100",1'b0, 3'b101, 32'h0000_0100, 32'h0,         5'd9,  32'h1234_ABCD, 0,  K_OK,    32'h0000_ABCD, 4'b0000, 32'h0);
        issue("SH 0x202", 1'b1, 3'b001, 32'h0000_0202, 32'h0000_1234, 5'd0,  32'h0,         0,  K_OK,    32'h0,         4'b1100, 32'h1234_1234);
        issue("SB 0x101", 1'b1, 3'b000, 32'h0000_0101, 32'h0000_00AB, 5'd0,  32'h0,         2,  K_OK,    32'h0,         4'b0010, 32'hABAB_ABAB);
        issue("SW 0x300", 1'b1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 5'd0,  32'h0,         3,  K_OK,    32'h0,         4'b1111, 32'hCAFE_F00D);
        issue("LW 0x102 misaligned", 1'b0, 3'b010, 32'h0000_0102, 32'h0, 5'd3, 32'h0, 0, K_FAULT, 32'h0, 4'b0000, 32'h0);
        issue("L f3=011",           1'b0, 3'b011, 32'h0000_0100, 32'h0, 5'd3, 32'h0, 0, K_FAULT, 32'h0, 4'b0000, 32'h0);
        issue("S f3=100",           1'b1, 3'b100, 32'h0000_0100, 32'h0, 5'd0, 32'h0, 0, K_FAULT, 32'h0, 4'b0000, 32'h0);
        issue("SH 0x201 misaligned",1'b1, 3'b001, 32'h0000_0201, 32'h0, 5'd0, 32'h0, 0, K_FAULT, 32'h0, 4'b0000, 32'h0);
        issue("LW timeout 1", 1'b0, 3'b010, 32'h0000_0400, 32'h0, 5'd4, 32'h0, -1, K_TMO, 32'h0, 4'b0000, 32'h0);
        issue("LW timeout 2", 1'b0, 3'b010, 32'h0000_0404, 32'h0, 5'd4, 32'h0, -1, K_TMO, 32'h0, 4'b0000, 32'h0);

        // Reset two cycles into a stalled store: dropped without a done pulse.
        @(negedge clk);
        while (!req_ready) @(negedge clk);
        req_valid = 1'b1;
        req_is_store = 1'b1;
        req_funct3 = 3'b010;
        req_addr = 32'h0000_0500;
        req_wdata = 32'h5555_AAAA;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("stall mem_req", mem_req, 1);
        chk("stall mem_we", mem_we, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst req_ready", req_ready, 1);
        chk("midrst mem_req", mem_req, 0);
        chk("midrst mem_we", mem_we, 0);
        chk("midrst mem_wstrb", mem_wstrb, 0);
        chk("midrst state", dbg_state, IDLE);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done) dcount++;
        end
        chk("no done after reset", dcount, 0);

        issue("LW after reset", 1'b0, 3'b010, 32'h0000_0600, 32'h0, 5'd31, 32'h0BAD_F00D, 0, K_OK, 32'h0BAD_F00D, 4'b0000, 32'h0);

        repeat (4) @(negedge clk);
        chk("exp_q drained", exp_q.size(), 0);
        chk("mem_exp_q drained", mem_exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
